// File: rtl/PairHMMPackage.sv
// Shared types and AXI constants for the PairHMM workgroup job/data and result paths.
// No state; one helper that builds write strobes from a lane count.
package PairHMMPackage;

    localparam int RESULT_WIDTH       = 64;
    localparam int RESULT_BYTES       = RESULT_WIDTH / 8;
    localparam int AXI_DATA_WIDTH     = 512;
    localparam int AXI_BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
    localparam int AXI_ADDR_WIDTH     = 64;
    localparam int AXI_ID_WIDTH       = 4;
    localparam int LANES              = AXI_DATA_WIDTH / RESULT_WIDTH;
    localparam int SLOT_CNT_W         = $clog2(LANES) + 1;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] likelihood;
    } result_t;

    function automatic logic [AXI_BYTES_PER_WORD-1:0] lane_strb(input int n_lanes);
        logic [AXI_BYTES_PER_WORD-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < n_lanes) s[i*RESULT_BYTES +: RESULT_BYTES] = '1;
        end
        return s;
    endfunction

endpackage

// File: rtl/cl_result_packer.sv
// Slot buffer: packs accepted results into 64-bit lanes, low lane first, and holds the
// captured word (data, lane count, strobes) stable until cleared after its B response.
module cl_result_packer
    import PairHMMPackage::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_accept,
    input  result_t                       i_result,
    input  logic                          i_capture,
    input  logic                          i_clear,
    output logic [SLOT_CNT_W-1:0]         o_slot_cnt,
    output logic [SLOT_CNT_W-1:0]         o_cnt_after,
    output logic [SLOT_CNT_W-1:0]         o_wcount,
    output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
    output logic [AXI_BYTES_PER_WORD-1:0] o_wstrb
);

    logic [LANES-1:0][RESULT_WIDTH-1:0] r_slots;
    logic [SLOT_CNT_W-1:0]              r_slot_cnt;
    logic [SLOT_CNT_W-1:0]              r_wcount;
    logic [SLOT_CNT_W-1:0]              w_cnt_after;
    logic [SLOT_CNT_W-2:0]              w_lane;

    assign w_lane      = r_slot_cnt[SLOT_CNT_W-2:0];
    assign w_cnt_after = r_slot_cnt + SLOT_CNT_W'(i_accept);

    // Lanes are zeroed once the word is retired so a later partial word carries zeros above its count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slots    <= '0;
            r_slot_cnt <= '0;
            r_wcount   <= '0;
        end else begin
            if (i_clear) begin
                r_slots <= '0;
            end else if (i_accept) begin
                r_slots[w_lane] <= i_result;
            end
            if (i_capture) begin
                r_wcount   <= w_cnt_after;
                r_slot_cnt <= '0;
            end else if (i_accept) begin
                r_slot_cnt <= w_cnt_after;
            end
        end
    end

    assign o_slot_cnt  = r_slot_cnt;
    assign o_cnt_after = w_cnt_after;
    assign o_wcount    = r_wcount;
    assign o_wdata     = r_slots;
    assign o_wstrb     = lane_strb(int'(r_wcount));

endmodule

// File: rtl/cl_result_writer.sv
// Packs job results into 512-bit words and writes them to a DDR ring over AXI AW/W/B.
// Full word reaches AW/W one cycle after the 8th accept; tready is low from capture until B.
module cl_result_writer
    import PairHMMPackage::*;
#(
    parameter int RESULTS_PER_WORD = AXI_DATA_WIDTH / RESULT_WIDTH,
    parameter int RING_SIZE_BYTES  = 65536,
    parameter int FLUSH_TIMEOUT    = 1024,
    parameter int DEBUG_VERBOSITY  = 0
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          i_result_tvalid,
    output logic                          o_result_tready,
    input  result_t                       i_result_tdata,
    output logic [AXI_ID_WIDTH-1:0]       o_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     o_axi_awaddr,
    output logic [7:0]                    o_axi_awlen,
    output logic [2:0]                    o_axi_awsize,
    output logic [1:0]                    o_axi_awburst,
    output logic                          o_axi_awvalid,
    input  logic                          i_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     o_axi_wdata,
    output logic [AXI_BYTES_PER_WORD-1:0] o_axi_wstrb,
    output logic                          o_axi_wlast,
    output logic                          o_axi_wvalid,
    input  logic                          i_axi_wready,
    input  logic                          i_axi_bvalid,
    input  logic [1:0]                    i_axi_bresp,
    output logic                          o_axi_bready,
    output logic                          o_axi_arvalid,
    output logic                          o_axi_rready,
    input  logic [AXI_ADDR_WIDTH-1:0]     base_addr_i,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic [31:0]                   results_written_o,
    output logic                          error_o
);

    if (RESULTS_PER_WORD != LANES || RING_SIZE_BYTES < AXI_BYTES_PER_WORD ||
        (RING_SIZE_BYTES & (RING_SIZE_BYTES - 1)) != 0 || FLUSH_TIMEOUT < 0 ||
        DEBUG_VERBOSITY < 0) begin : g_bad_params
        $error("cl_result_writer: unsupported parameter combination");
    end

    localparam int OFF_W = $clog2(RING_SIZE_BYTES);
    localparam int TO_W  = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_WAIT_B  = 2'd2;

    logic [1:0]        r_state;
    logic              r_aw_done;
    logic              r_w_done;
    logic [OFF_W-1:0]  r_offset;
    logic [TO_W-1:0]   r_timeout;
    logic [31:0]       r_results_written;
    logic              r_error;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_timeout_hit;
    logic                  w_capture;
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_write_done;
    logic                  w_b_fire;
    logic [SLOT_CNT_W-1:0] w_slot_cnt;
    logic [SLOT_CNT_W-1:0] w_cnt_after;
    logic [SLOT_CNT_W-1:0] w_wcount;

    assign w_accept      = i_result_tvalid && (r_state == ST_COLLECT);
    assign w_full        = w_accept && (w_cnt_after == SLOT_CNT_W'(RESULTS_PER_WORD));
    assign w_timeout_hit = (FLUSH_TIMEOUT != 0) && (r_timeout == TO_W'(FLUSH_TIMEOUT - 1));
    assign w_capture     = (r_state == ST_COLLECT) &&
                           (w_full || ((w_cnt_after != '0) && (flush_i || w_timeout_hit)));
    assign w_aw_fire     = o_axi_awvalid && i_axi_awready;
    assign w_w_fire      = o_axi_wvalid && i_axi_wready;
    assign w_write_done  = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);
    assign w_b_fire      = (r_state == ST_WAIT_B) && i_axi_bvalid;

    cl_result_packer u_packer (
        .i_clk       (clock_i),
        .i_rst       (reset_i),
        .i_accept    (w_accept),
        .i_result    (i_result_tdata),
        .i_capture   (w_capture),
        .i_clear     (w_b_fire),
        .o_slot_cnt  (w_slot_cnt),
        .o_cnt_after (w_cnt_after),
        .o_wcount    (w_wcount),
        .o_wdata     (o_axi_wdata),
        .o_wstrb     (o_axi_wstrb)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state           <= ST_COLLECT;
            r_aw_done         <= 1'b0;
            r_w_done          <= 1'b0;
            r_offset          <= '0;
            r_timeout         <= '0;
            r_results_written <= '0;
            r_error           <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_capture) begin
                        r_state   <= ST_WRITE;
                        r_timeout <= '0;
                    end else if (w_accept) begin
                        r_timeout <= '0;
                    end else if (w_slot_cnt != '0) begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_write_done) begin
                        r_state   <= ST_WAIT_B;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_fire) r_aw_done <= 1'b1;
                        if (w_w_fire)  r_w_done  <= 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    // The offset register is exactly log2(ring) bits wide, so the add wraps to 0 at the ring end.
                    if (i_axi_bvalid) begin
                        r_results_written <= r_results_written + 32'(w_wcount);
                        r_error           <= r_error || (i_axi_bresp != AXI_RESP_OKAY);
                        r_offset          <= r_offset + OFF_W'(AXI_BYTES_PER_WORD);
                        r_state           <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign o_result_tready   = (r_state == ST_COLLECT);
    assign o_axi_awvalid     = (r_state == ST_WRITE) && !r_aw_done;
    assign o_axi_wvalid      = (r_state == ST_WRITE) && !r_w_done;
    assign o_axi_awid        = '0;
    assign o_axi_awaddr      = base_addr_i + AXI_ADDR_WIDTH'(r_offset);
    assign o_axi_awlen       = 8'd0;
    assign o_axi_awsize      = AXI_SIZE_64B;
    assign o_axi_awburst     = AXI_BURST_INCR;
    assign o_axi_wlast       = 1'b1;
    assign o_axi_bready      = 1'b1;
    assign o_axi_arvalid     = 1'b0;
    assign o_axi_rready      = 1'b1;
    assign busy_o            = (r_state != ST_COLLECT) || (w_slot_cnt != '0);
    assign results_written_o = r_results_written;
    assign error_o           = r_error;

endmodule

// File: tb/tb_cl_result_writer.sv
// Directed bench for cl_result_writer: expected AXI writes are queued by the stimulus and
// checked by an independent monitor; a reactive AXI slave model supplies programmable delays.
module tb_cl_result_writer;
    import PairHMMPackage::*;

    localparam int RING = 128;
    localparam int TOUT = 16;
    localparam logic [63:0] BASE = 64'h1000;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          tvalid = 1'b0;
    logic                          tready;
    result_t                       tdata = '0;
    logic [AXI_ID_WIDTH-1:0]       awid;
    logic [63:0]                   awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready = 1'b0;
    logic [511:0]                  wdata;
    logic [63:0]                   wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready = 1'b0;
    logic                          bvalid = 1'b0;
    logic [1:0]                    bresp = 2'b00;
    logic                          bready;
    logic                          arvalid;
    logic                          rready;
    logic [63:0]                   base_addr = BASE;
    logic                          flush = 1'b0;
    logic                          busy;
    logic [31:0]                   results_written;
    logic                          error;

    always #5 clk = ~clk;

    cl_result_writer #(
        .RESULTS_PER_WORD (8),
        .RING_SIZE_BYTES  (RING),
        .FLUSH_TIMEOUT    (TOUT),
        .DEBUG_VERBOSITY  (0)
    ) dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .i_result_tvalid   (tvalid),
        .o_result_tready   (tready),
        .i_result_tdata    (tdata),
        .o_axi_awid        (awid),
        .o_axi_awaddr      (awaddr),
        .o_axi_awlen       (awlen),
        .o_axi_awsize      (awsize),
        .o_axi_awburst     (awburst),
        .o_axi_awvalid     (awvalid),
        .i_axi_awready     (awready),
        .o_axi_wdata       (wdata),
        .o_axi_wstrb       (wstrb),
        .o_axi_wlast       (wlast),
        .o_axi_wvalid      (wvalid),
        .i_axi_wready      (wready),
        .i_axi_bvalid      (bvalid),
        .i_axi_bresp       (bresp),
        .o_axi_bready      (bready),
        .o_axi_arvalid     (arvalid),
        .o_axi_rready      (rready),
        .base_addr_i       (base_addr),
        .flush_i           (flush),
        .busy_o            (busy),
        .results_written_o (results_written),
        .error_o           (error)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic [63:0] addr, input int id0, input int n, input logic [31:0] lik0);
        exp_t e;
        e.addr = addr;
        e.data = '0;
        e.strb = '0;
        for (int i = 0; i < n; i++) begin
            e.data[i*64 +: 64] = {32'(id0 + i), lik0 + 32'(i)};
            e.strb[i*8 +: 8]   = 8'hFF;
        end
        exp_q.push_back(e);
    endtask

    // Slave model: decisions made at negedge take effect at the following posedge.
    int         aw_delay = 0;
    int         w_delay = 0;
    logic [1:0] bresp_sel = 2'b00;
    initial begin
        bit aw_fire = 0, w_fire = 0, b_fire = 0, got_aw = 0, got_w = 0, b_pend = 0;
        int aw_wait = 0, w_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_fire = 0; w_fire = 0; b_fire = 0; got_aw = 0; got_w = 0; b_pend = 0;
                aw_wait = 0; w_wait = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            end else begin
                if (aw_fire) got_aw = 1;
                if (w_fire)  got_w = 1;
                if (b_fire)  bvalid = 1'b0;
                if (b_pend) begin
                    bvalid = 1'b1;
                    bresp  = bresp_sel;
                    b_pend = 0;
                end
                if (got_aw && got_w) begin
                    b_pend = 1; got_aw = 0; got_w = 0;
                end
                if (awvalid && aw_wait < aw_delay) begin
                    awready = 1'b0; aw_wait++;
                end else awready = awvalid;
                if (wvalid && w_wait < w_delay) begin
                    wready = 1'b0; w_wait++;
                end else wready = wvalid;
                aw_fire = awvalid && awready;
                w_fire  = wvalid && wready;
                if (aw_fire) aw_wait = 0;
                if (w_fire)  w_wait = 0;
                b_fire = bvalid && bready;
            end
        end
    end

    // Monitor: observes the AXI channels and scores each completed AW+W pair.
    int aw_cycles = 0, w_cycles = 0, b_count = 0, tready_in_flight = 0;
    initial begin
        bit have_aw = 0, have_w = 0, in_flight = 0;
        logic [63:0]  cap_addr;
        logic [511:0] cap_data;
        logic [63:0]  cap_strb;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                have_aw = 0; have_w = 0; in_flight = 0;
            end else begin
                if (awvalid) aw_cycles++;
                if (wvalid)  w_cycles++;
                if (awvalid || wvalid) in_flight = 1;
                if (in_flight && tready) tready_in_flight++;
                if (bvalid && bready) begin
                    b_count++; in_flight = 0;
                end
                if (awvalid && awready) begin
                    cap_addr = awaddr; have_aw = 1;
                end
                if (wvalid && wready) begin
                    cap_data = wdata; cap_strb = wstrb; have_w = 1;
                end
                if (have_aw && have_w) begin
                    have_aw = 0; have_w = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: got addr %0h expected no write", cap_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("awaddr", cap_addr, e.addr);
                        check("wstrb", cap_strb, e.strb);
                        check("wdata", cap_data, e.data);
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; tvalid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] id, input logic [31:0] lik);
        int  n = 0;
        bit  ok = 0;
        tvalid = 1'b1;
        tdata  = '{id: id, likelihood: lik};
        while (!ok && n < 200) begin
            ok = tready;
            @(posedge clk);
            if (!ok) @(negedge clk);
            n++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: got no tready in %0d cycles expected acceptance", n);
        end
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL idle_timeout: got busy_o=1 after %0d cycles expected 0", n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        reset_dut();
        check("rst_busy", busy, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_written", results_written, 0);
        check("rst_error", error, 0);
        check("rst_tready", tready, 1);

        // Test 1: full word, always-ready slave, accept-to-tready latency
        push_exp(64'h1000, 0, 8, 32'h3F80_0000);
        for (int i = 0; i < 8; i++) send(32'(i), 32'h3F80_0000 + 32'(i));
        k = 1;
        while (!tready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t1_tready_latency", k, 4);
        wait_idle();
        check("t1_written", results_written, 8);

        // Test 2: partial word via flush, then next word lands at +0x40
        reset_dut();
        push_exp(64'h1000, 16, 3, 32'h4000_0000);
        for (int i = 0; i < 3; i++) send(32'(16 + i), 32'h4000_0000 + 32'(i));
        pulse_flush();
        wait_idle();
        check("t2_written", results_written, 3);
        push_exp(64'h1040, 32, 1, 32'h4100_0000);
        send(32'd32, 32'h4100_0000);
        pulse_flush();
        wait_idle();
        check("t2_written_2", results_written, 4);

        // Test 3: ring of 128 bytes wraps after two words
        reset_dut();
        push_exp(64'h1000, 64, 8, 32'h4200_0000);
        push_exp(64'h1040, 72, 8, 32'h4200_0008);
        push_exp(64'h1000, 80, 8, 32'h4200_0010);
        for (int i = 0; i < 24; i++) send(32'(64 + i), 32'h4200_0000 + 32'(i));
        wait_idle();
        check("t3_written", results_written, 24);

        // Test 4: awready delayed 5 cycles, wready immediate
        reset_dut();
        aw_delay = 5;
        aw_cycles = 0; w_cycles = 0; b_count = 0; tready_in_flight = 0;
        push_exp(64'h1000, 96, 2, 32'h4300_0000);
        send(32'd96, 32'h4300_0000);
        send(32'd97, 32'h4300_0001);
        pulse_flush();
        wait_idle();
        check("t4_awvalid_cycles", aw_cycles, 6);
        check("t4_wvalid_cycles", w_cycles, 1);
        check("t4_b_count", b_count, 1);
        check("t4_tready_in_flight", tready_in_flight, 0);
        aw_delay = 0;

        // Test 5: timeout flush of one result (16 idle cycles, AW/W on the 17th), SLVERR is sticky
        reset_dut();
        bresp_sel = 2'b10;
        push_exp(64'h1000, 128, 1, 32'h4400_0000);
        send(32'd128, 32'h4400_0000);
        k = 1;
        while (!awvalid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_timeout_awvalid_cycle", k, 17);
        wait_idle();
        check("t5_error_set", error, 1);
        check("t5_written", results_written, 1);
        bresp_sel = 2'b00;
        push_exp(64'h1040, 129, 1, 32'h4400_0001);
        send(32'd129, 32'h4400_0001);
        pulse_flush();
        wait_idle();
        check("t5_error_sticky", error, 1);
        check("t5_written_2", results_written, 2);

        // Test 6: asynchronous reset while in WRITE drops valids at once, offset restarts
        reset_dut();
        push_exp(64'h1000, 160, 1, 32'h4500_0000);
        send(32'd160, 32'h4500_0000);
        pulse_flush();
        wait_idle();
        aw_delay = 20; w_delay = 20;
        send(32'd161, 32'h4500_0001);
        pulse_flush();
        repeat (3) @(negedge clk);
        check("t6_in_write", awvalid && wvalid, 1);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_awvalid", awvalid, 0);
        check("t6_rst_wvalid", wvalid, 0);
        check("t6_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        aw_delay = 0; w_delay = 0;
        push_exp(64'h1000, 162, 1, 32'h4500_0002);
        send(32'd162, 32'h4500_0002);
        pulse_flush();
        wait_idle();
        check("t6_written", results_written, 1);

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cl_result_writer.md
Name: cl_result_writer

Overview:
- Write-side counterpart of the workgroup job/data fetch path.
- Collects per-job results (job id + 32-bit float likelihood) from the workgroup's workers and packs them into 512-bit words.
- Writes each packed word to a DDR4 ring buffer through the AXI write channels (AW/W/B).
- The host reads results from the ring buffer. The block never drives the AXI read channels.

Parameters:
- RESULTS_PER_WORD, 8, 64-bit result slots per 512-bit AXI word; fixed at AXI_DATA_WIDTH/64.
- RING_SIZE_BYTES, 65536, ring buffer size in bytes; power of two, multiple of 64.
- FLUSH_TIMEOUT, 1024, idle cycles after the last accepted result before a partial word is written; 0 disables the timeout.
- DEBUG_VERBOSITY, 0, simulation message level.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  reset, asynchronous, active-high
- result_bus  slave  axi_stream_generic_if  tdata is PairHMMPackage::result_t (64 bits: [63:32] id, [31:0] likelihood); tvalid/tready handshake
- axi_bus  master  axi_if  AXI4 512-bit; AW/W/B driven, AR/R tied off (arvalid=0, rready=1)
- base_addr_i  in  64  ring base address; 64-byte aligned; must be stable while busy_o=1
- flush_i  in  1  level request to write any partially filled word
- busy_o  out  1  slot buffer non-empty or write in flight
- results_written_o  out  32  count of results whose write got a B response; wraps at 2^32
- error_o  out  1  sticky; set on any bresp != OKAY

Behaviour:
- Reset (async assert, synchronous-release assumption on reset_i):
  - State = COLLECT; slot counter 0; offset 0; timeout counter 0; results_written_o 0; error_o 0; busy_o 0.
  - awvalid = 0, wvalid = 0.
  - Reset mid-transaction drops valids immediately; in-flight data is lost.
- Static AXI fields:
  - awid 0, awlen 0, awsize 3'b110, awburst 2'b01, wlast 1, bready 1.
  - awaddr = base_addr_i + offset_reg.
- States: COLLECT, WRITE, WAIT_B.
- COLLECT:
  - result_bus.tready = 1 only in COLLECT.
  - On tvalid&&tready: tdata is stored in lane slot_cnt (bits [slot_cnt*64 +: 64]); slot_cnt increments; the timeout counter clears.
  - When the accept fills the lane RESULTS_PER_WORD-1: slot_cnt_reg is captured to wcount = 8, slot_cnt returns to 0, next state WRITE.
  - Otherwise, if slot_cnt>0 (after the accept) and (flush_i or timeout counter == FLUSH_TIMEOUT-1): next state WRITE.
    - A result accepted in the same cycle as a flush is included in the word.
  - flush_i with an empty buffer is a no-op.
  - The timeout counter increments each COLLECT cycle with slot_cnt>0 and no accept.
- WRITE:
  - awvalid and wvalid are asserted together from the first cycle.
  - aw_done/w_done flags are set independently on awready / wready.
  - wstrb = 8 bytes × wcount lanes, low lanes first; unused lanes have data 0.
  - Next state is WAIT_B once both handshakes are complete, including the same cycle.
  - A valid signal must never drop before its ready is seen.
- WAIT_B:
  - On bvalid: results_written_o += wcount.
  - If bresp != 2'b00, error_o is set (sticky). The write is not retried.
  - offset_reg = (offset_reg + 64) mod RING_SIZE_BYTES; wrap-around returns to offset 0.
  - Next state COLLECT.
- One write is outstanding at most; there is no backpressure toward the host beyond tready=0.
- busy_o = (state != COLLECT) || (slot_cnt != 0).
- Latency: the 8th result is accepted at cycle t → awvalid/wvalid high at t+1. With an always-ready slave, bvalid at t+3 → tready high again at t+4.

Decomposition:
- PairHMMPackage gains:
  - result_t (id 32 bits, likelihood 32 bits).
  - RESULT_WIDTH = 64.
  - AXI_BYTES_PER_WORD = 64, which replaces the magic 64 used in address arithmetic.
- Sub-module cl_result_packer: slot registers, lane select, wstrb generation and slot counter. The FSM, AXI handshake flags and address counter stay in cl_result_writer.

Test Plan:
1. base 0x1000; 8 results (id 0..7, likelihood 0x3F800000+i); always-ready slave → one write to awaddr 0x1000, wstrb all-ones, lane i = {i, 0x3F800000+i}; results_written_o = 8.
2. 3 results then flush_i pulse → one write, wstrb = 0x0000_0000_00FF_FFFF, lanes 3..7 zero; results_written_o = 3; a following write goes to 0x1040.
3. RING_SIZE_BYTES = 128; 24 results → awaddr sequence 0x1000, 0x1040, 0x1000 (wrap).
4. awready delayed 5 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid is held 6 cycles, exactly one B; tready stays low throughout.
5. FLUSH_TIMEOUT = 16; 1 result then idle → write issued 16 cycles after the accept; bresp = SLVERR → error_o = 1 and stays 1 after the next OKAY write.
6. Assert reset_i while in WRITE → awvalid/wvalid/busy_o = 0 in the same cycle, without waiting for a clock edge; the next write after release goes to base_addr_i + 0.
